pulse_led_drive: RTL
====================

Name: pulse_led_drive

Overview:
Converts single-cycle active-high event pulses into visible active-low flashes on an LED or other indicator output. Each pulse becomes one low period of fixed length, followed by a mandatory high gap so back-to-back events remain distinguishable. Pulses that arrive during a flash are queued in a saturating pending counter; overflow is flagged. It sits downstream of press-to-pulse and event logic and drives board outputs directly.

Parameters:
HOLD_CYCLES, 4, cycles the output is held low per flash; must be >= 1
GAP_CYCLES, 2, cycles the output is forced high after each flash; must be >= 1
MAX_PENDING, 3, maximum queued flashes not yet started; must be >= 1

Ports:
clk  input  1  single system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
in  input  1  active-high event pulse, sampled every cycle
out  output  1  active-low indicator drive, registered
busy  output  1  high whenever state is not IDLE
pending  output  $clog2(MAX_PENDING+1)  queued flash count, registered
drop  output  1  one-cycle high when a pulse is discarded because the queue is full

Behaviour:
- Reset is synchronous: rst_n low at a posedge gives out=1, busy=0, pending=0, drop=0, state IDLE and cleared counters on that edge. Reset mid-flash aborts the flash. Queued pulses are discarded without asserting drop.
- State machine has three states: IDLE, ON and GAP. The single down-counter is sized for max(HOLD_CYCLES, GAP_CYCLES).
- IDLE: out=1. If in=1, go to ON on the next edge with out=0. A pulse sampled in cycle k drives out low in cycles k+1..k+HOLD_CYCLES.
- ON: out=0 for exactly HOLD_CYCLES cycles, then GAP.
- GAP: out=1 for exactly GAP_CYCLES cycles.
  - At the end of the last GAP cycle, go to ON if pending>0 or in=1; otherwise go to IDLE.
  - A chained flash starts with no IDLE cycle between flashes, and busy stays high.
- Pulse accounting, evaluated every cycle while in ON or GAP:
  - in=1 with pending<MAX_PENDING gives pending+1.
  - in=1 with pending=MAX_PENDING: pending is unchanged and drop=1 in the next cycle.
- Last GAP cycle, all combinations:
  - pending>0 and in=0: pending-1.
  - pending>0 and in=1: pending unchanged (the pulse consumes the slot being freed), no drop, even when pending=MAX_PENDING.
  - pending=0 and in=1: start flashing the new pulse directly, pending stays 0.
- in held high for N consecutive cycles counts as N separate pulses. The input contract is single-cycle pulses; no edge detection is performed.
- busy is decoded from the state register (state != IDLE), so it changes in the same cycle as out.
- drop is registered and high for exactly one cycle per discarded pulse.
- pending never wraps, never exceeds MAX_PENDING and never underflows.
- Bad parameters: HOLD_CYCLES=0 or GAP_CYCLES=0 is illegal. A simulation-only check must error at time 0.

Test Plan:
(All scenarios use defaults HOLD=4, GAP=2, MAX=3; cycle numbers are sample cycles of in.)
- Single pulse at cycle 10 -> out=0 in cycles 11-14, out=1 from 15; busy=1 in cycles 11-16, busy=0 from 17; pending=0 and drop=0 throughout.
- Pulses at cycles 10, 11, 12 -> pending=1 at 12, pending=2 at 13; out low in 11-14, 17-20 and 23-26; pending=0 from 23; busy=0 from 29.
- Pulses at cycles 10-14 (in held 5 cycles) -> pending saturates at 3 (cycle 14); drop=1 only in cycle 15; exactly four low periods (11-14, 17-20, 23-26, 29-32).
- Pulse at 10, second pulse at 16 (last GAP cycle, pending=0) -> out low 11-14 and 17-20; busy never drops between flashes; pending stays 0.
- Queue full plus pulse on last GAP cycle: pulses at 10-13 fill pending=3, extra pulse at 16 -> pending stays 3, drop stays 0, five flashes total.
- Pulses at 10 and 11, then rst_n=0 in cycle 12 -> out=1, busy=0, pending=0 from 13, drop=0; pulse at 15 after release -> out low in 16-19.

Source files
------------

// File: rtl/pulse_led_drive.sv
// pulse_led_drive
// Turns single-cycle active-high event pulses into active-low flashes of
// HOLD_CYCLES, each followed by a GAP_CYCLES high gap. Pulses that arrive
// while a flash is running are queued in a saturating counter. A pulse that
// arrives when the queue is already full is discarded and reported on drop.

module pulse_led_drive #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in,
    output logic                             out,
    output logic                             busy,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending,
    output logic                             drop
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PEND_W  = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    // Zero-length flashes, zero-length gaps or an empty queue are illegal.
    // Elaboration-time checks, so they report at time 0.
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pulse_led_drive: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pulse_led_drive: GAP_CYCLES must be >= 1");
    end
    if (MAX_PENDING < 1) begin : g_bad_max
        $error("pulse_led_drive: MAX_PENDING must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              pend_full;
    logic              last_gap;

    // Queue-full and last-gap-cycle decodes shared by the sequencer below.
    always_comb begin
        pend_full = (pending == PEND_MAX);
        last_gap  = (state == GAP) && (cnt == '0);
    end

    // busy follows the state register directly so it moves with out.
    assign busy = (state != IDLE);

    // Flash sequencer, down-counter, pending queue and drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            out     <= 1'b1;
            pending <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;

            // Pulses seen mid-flash (other than on the last gap cycle) are
            // queued, or flagged as dropped once the queue is full.
            if ((state == ON || state == GAP) && !last_gap && in) begin
                if (pend_full) begin
                    drop <= 1'b1;
                end else begin
                    pending <= pending + PEND_ONE;
                end
            end

            case (state)
                IDLE: begin
                    out <= 1'b1;
                    if (in) begin
                        state <= ON;
                        cnt   <= HOLD_LOAD;
                        out   <= 1'b0;
                    end
                end

                ON: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= GAP_LOAD;
                        out   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == '0) begin
                        // A pulse on this cycle takes over the slot being
                        // freed, so pending only shrinks when in is low.
                        if (pending != '0 || in) begin
                            state <= ON;
                            cnt   <= HOLD_LOAD;
                            out   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            out   <= 1'b1;
                        end
                        if (pending != '0 && !in) begin
                            pending <= pending - PEND_ONE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    out   <= 1'b1;
                end
            endcase
        end
    end

endmodule
